mem_responder: RTL and testbench

- Memory-side responder for the processor control FSM's memory interface.
- Accepts memread/memwrite/fetch requests with address and writedata. Services them against an internal word-addressed RAM with programmable latency.
- Returns read data, or the fetched 16-bit instruction word, with a one-cycle completion pulse.
- Sits between the control state machine and storage; one port serves both instruction fetch and data access.

---
 rtl/mem_responder_pkg.sv | 5 +
 rtl/mem_responder_sp_ram.sv | 21 ++
 rtl/mem_responder.sv | 114 +++++++++++
 tb/tb_mem_responder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: state encoding and data width shared with the control FSM
package mem_responder_pkg;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;
endpackage

// File: rtl/mem_responder_sp_ram.sv
// sp_ram: single-port synchronous RAM with write enable and registered read
module sp_ram
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata_q <= mem[addr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: latency-programmable memory responder serving fetch and data access
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH = 256,
  parameter int READ_LAT = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic              fetch,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic [DATA_W-1:0] instruction,
  output logic              memready,
  output logic              busy,
  output logic              error
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int MAXL = READ_LAT > WRITE_LAT ? READ_LAT : WRITE_LAT;
  localparam int CW = $clog2(MAXL) + 1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, ram_addr;
  logic [DATA_W-1:0] wdata_q, wdata_d, readdata_q, readdata_d, instr_q, instr_d, ram_rdata;
  logic is_wr_q, is_wr_d, fetch_q, fetch_d;
  logic memready_q, memready_d, busy_q, busy_d, error_q, error_d;
  logic oob, ram_we;
  // RAM reads the live address in IDLE so data is ready even when the latency is one cycle
  assign ram_addr = state_q == IDLE ? addr : addr_q;
  assign oob = 32'(ram_addr) >= DEPTH;
  assign ram_we = state_q == DONE && is_wr_q && !oob && !reset;
  sp_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk),
    .we(ram_we),
    .addr(ram_addr[AW-1:0]),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    fetch_d = fetch_q;
    readdata_d = readdata_q;
    instr_d = instr_q;
    memready_d = 1'b0;
    error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (memread && memwrite) begin
          error_d = 1'b1;
        end else if (memread || memwrite) begin
          addr_d = addr;
          wdata_d = writedata;
          is_wr_d = memwrite;
          fetch_d = fetch;
          cnt_d = memwrite ? CW'(WRITE_LAT - 2) : CW'(READ_LAT - 2);
          state_d = memwrite ? (WRITE_LAT == 1 ? DONE : WR_WAIT) : (READ_LAT == 1 ? DONE : RD_WAIT);
        end
      end
      RD_WAIT, WR_WAIT: begin
        state_d = cnt_q == '0 ? DONE : state_q;
        cnt_d = cnt_q - 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        memready_d = 1'b1;
        error_d = oob;
        instr_d = !is_wr_q && fetch_q ? (oob ? '0 : ram_rdata) : instr_q;
        readdata_d = !is_wr_q && !fetch_q ? (oob ? '0 : ram_rdata) : readdata_q;
      end
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      fetch_q <= 1'b0;
      readdata_q <= '0;
      instr_q <= '0;
      memready_q <= 1'b0;
      busy_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      fetch_q <= fetch_d;
      readdata_q <= readdata_d;
      instr_q <= instr_d;
      memready_q <= memready_d;
      busy_q <= busy_d;
      error_q <= error_d;
    end
  end
  assign readdata = readdata_q;
  assign instruction = instr_q;
  assign memready = memready_q;
  assign busy = busy_q;
  assign error = error_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed table, corner sequences and randomized model check
module tb_mem_responder;
  localparam int RL = 2;
  localparam int WL = 1;
  logic clk = 1'b0;
  logic reset, memread, memwrite, fetch;
  logic [8:0] addr;
  logic [15:0] writedata, readdata, instruction;
  logic memready, busy, error;
  int errors = 0;
  int checks = 0;
  logic [15:0] m_mem [256];
  int wq[$];
  logic [15:0] m_rd, m_ins;

  mem_responder #(.ADDR_W(9), .DEPTH(256), .READ_LAT(RL), .WRITE_LAT(WL)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite), .fetch(fetch),
    .addr(addr), .writedata(writedata), .readdata(readdata), .instruction(instruction),
    .memready(memready), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic rd, wr, f;
    logic [8:0] a;
    logic [15:0] wd;
    int rk, ek;
    logic [15:0] exp_rd, exp_ins;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference behaviour: RAM as an array, out-of-range writes dropped, reads return 0
  task automatic model(input logic rd, input logic wr, input logic f, input int a, input logic [15:0] wd);
    if (wr && !rd && a < 256) begin
      m_mem[a] = wd;
      wq.push_back(a);
    end
    if (rd && !wr) begin
      if (f) m_ins = a < 256 ? m_mem[a] : 16'h0;
      else m_rd = a < 256 ? m_mem[a] : 16'h0;
    end
  endtask

  task automatic do_access(input string name, input logic rd, input logic wr, input logic f,
                           input logic [8:0] a, input logic [15:0] wd, input int rk_exp,
                           input int ek_exp, input logic [15:0] rd_exp, input logic [15:0] ins_exp);
    int rk, ek, np;
    rk = 0; ek = 0; np = 0;
    @(negedge clk);
    memread = rd; memwrite = wr; fetch = f; addr = a; writedata = wd;
    @(negedge clk);
    memread = 0; memwrite = 0; fetch = 0;
    chk({name, ".busy"}, 32'(busy), 32'(rk_exp != 0));
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) @(negedge clk);
      if (memready && rk == 0) rk = k;
      if (error && ek == 0) ek = k;
      np += int'(memready);
    end
    chk({name, ".ready_cycle"}, 32'(rk), 32'(rk_exp));
    chk({name, ".pulses"}, 32'(np), 32'(rk_exp != 0));
    chk({name, ".error_cycle"}, 32'(ek), 32'(ek_exp));
    chk({name, ".readdata"}, 32'(readdata), 32'(rd_exp));
    chk({name, ".instruction"}, 32'(instruction), 32'(ins_exp));
  endtask

  initial begin
    int rk, np, ek;
    tbl[0]  = '{"wr3", 0, 1, 0, 9'd3, 16'h2040, WL+1, 0, 16'h0, 16'h0};
    tbl[1]  = '{"fetch3", 1, 0, 1, 9'd3, 16'h0, RL+1, 0, 16'h0, 16'h2040};
    tbl[2]  = '{"wr44", 0, 1, 0, 9'd44, 16'h1234, WL+1, 0, 16'h0, 16'h2040};
    tbl[3]  = '{"wr5", 0, 1, 0, 9'd5, 16'h0A5A, WL+1, 0, 16'h0, 16'h2040};
    tbl[4]  = '{"wr300", 0, 1, 0, 9'd300, 16'hFFFF, WL+1, WL+1, 16'h0, 16'h2040};
    tbl[5]  = '{"rd44", 1, 0, 0, 9'd44, 16'h0, RL+1, 0, 16'h1234, 16'h2040};
    tbl[6]  = '{"rd300", 1, 0, 0, 9'd300, 16'h0, RL+1, RL+1, 16'h0, 16'h2040};
    tbl[7]  = '{"rd44b", 1, 0, 0, 9'd44, 16'h0, RL+1, 0, 16'h1234, 16'h2040};
    tbl[8]  = '{"illegal", 1, 1, 0, 9'd3, 16'h1111, 0, 1, 16'h1234, 16'h2040};
    tbl[9]  = '{"fetch5", 1, 0, 1, 9'd5, 16'h0, RL+1, 0, 16'h1234, 16'h0A5A};
    tbl[10] = '{"fetch_only", 0, 0, 1, 9'd3, 16'h0, 0, 0, 16'h1234, 16'h0A5A};
    m_rd = 0; m_ins = 0;
    reset = 1; memread = 0; memwrite = 0; fetch = 0; addr = 0; writedata = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    chk("reset.readdata", 32'(readdata), 0);
    chk("reset.instruction", 32'(instruction), 0);
    chk("reset.memready", 32'(memready), 0);
    chk("reset.busy", 32'(busy), 0);
    chk("reset.error", 32'(error), 0);
    foreach (tbl[i]) begin
      do_access(tbl[i].name, tbl[i].rd, tbl[i].wr, tbl[i].f, tbl[i].a, tbl[i].wd,
                tbl[i].rk, tbl[i].ek, tbl[i].exp_rd, tbl[i].exp_ins);
      model(tbl[i].rd, tbl[i].wr, tbl[i].f, int'(tbl[i].a), tbl[i].wd);
    end
    // write attempt while busy with a read must be ignored
    @(negedge clk);
    memread = 1; fetch = 0; addr = 9'd3;
    @(negedge clk);
    memread = 0; memwrite = 1; writedata = 16'hDEAD;
    chk("busyw.busy", 32'(busy), 1);
    rk = 0; np = 0;
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk);
      memwrite = 0;
      if (memready && rk == 0) rk = k;
      np += int'(memready);
    end
    chk("busyw.ready_cycle", 32'(rk), RL + 1);
    chk("busyw.pulses", 32'(np), 1);
    chk("busyw.readdata", 32'(readdata), 32'h2040);
    model(1, 0, 0, 3, 0);
    do_access("busyw.fetch3", 1, 0, 1, 9'd3, 16'h0, RL+1, 0, m_rd, 16'h2040);
    model(1, 0, 1, 3, 0);
    // held request: re-accepted right after completion, spacing RL+1
    @(negedge clk);
    memread = 1; fetch = 1; addr = 9'd44;
    rk = 0; np = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (memready) begin
        np++;
        if (np == 2) rk = k;
      end
    end
    memread = 0; fetch = 0;
    repeat (5) @(negedge clk);
    chk("b2b.second_ready", 32'(rk), 2 * (RL + 1));
    chk("b2b.instruction", 32'(instruction), 32'h1234);
    model(1, 0, 1, 44, 0);
    // reset during a write aborts it
    @(negedge clk);
    memwrite = 1; addr = 9'd5; writedata = 16'hBEEF;
    @(negedge clk);
    memwrite = 0; reset = 1;
    @(negedge clk);
    reset = 0;
    np = 0; ek = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      np += int'(memready);
      ek += int'(error);
    end
    chk("rstmid.pulses", 32'(np), 0);
    chk("rstmid.error", 32'(ek), 0);
    chk("rstmid.busy", 32'(busy), 0);
    chk("rstmid.readdata", 32'(readdata), 0);
    chk("rstmid.instruction", 32'(instruction), 0);
    m_rd = 0; m_ins = 0;
    do_access("rstmid.rd5", 1, 0, 0, 9'd5, 16'h0, RL+1, 0, 16'h0A5A, 16'h0);
    model(1, 0, 0, 5, 0);
    for (int n = 0; n < 40; n++) begin
      int op, a, rkx, ekx;
      logic f;
      logic [15:0] wd, erd, eins;
      op = int'($urandom_range(0, 9));
      f = 1'($urandom_range(0, 1));
      wd = 16'($urandom);
      if (op >= 5) a = $urandom_range(0, 7) == 0 ? int'($urandom_range(256, 511)) : wq[$urandom_range(0, wq.size() - 1)];
      else a = $urandom_range(0, 9) == 0 ? int'($urandom_range(256, 511)) : int'($urandom_range(0, 255));
      erd = m_rd; eins = m_ins;
      if (op == 0) begin
        rkx = 0; ekx = 1;
        do_access("rand.illegal", 1, 1, f, 9'(a), wd, rkx, ekx, erd, eins);
        model(1, 1, f, a, wd);
      end else if (op <= 4) begin
        rkx = WL + 1; ekx = a >= 256 ? WL + 1 : 0;
        do_access("rand.write", 0, 1, f, 9'(a), wd, rkx, ekx, erd, eins);
        model(0, 1, f, a, wd);
      end else begin
        rkx = RL + 1; ekx = a >= 256 ? RL + 1 : 0;
        if (f) eins = a < 256 ? m_mem[a] : 16'h0;
        else erd = a < 256 ? m_mem[a] : 16'h0;
        do_access("rand.read", 1, 0, f, 9'(a), wd, rkx, ekx, erd, eins);
        model(1, 0, f, a, wd);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
